// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU, LSU) arbiter onto a single memory port.
// It tracks one outstanding transaction through IDLE -> REQ -> WAIT -> RESP.
// A tie between the two requesters is broken round-robin using last_grant.
//
// Parameters:
//   ADDR_W   address width of all address ports.
//   TIMEOUT  number of WAIT cycles before a transaction is aborted
//            (only used when MEM_ARB_TIMEOUT_EN is defined).
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, a transaction that stays in WAIT for TIMEOUT cycles is
//   completed with rdata 32'hDEADBEEF, and the sticky err flag is set.
//   When undefined, WAIT lasts until mem_rsp_valid arrives and err is 0.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ifu_req_valid/ready      IFU request handshake; ifu_addr is the read address
//   ifu_rsp_valid/ifu_rdata  IFU response pulse and read data (held between responses)
//   lsu_req_valid/ready      LSU request handshake; lsu_addr/wen/wdata/wmask
//   lsu_rsp_valid/lsu_rdata  LSU response pulse (also the write ack) and read data
//   mem_req_valid/ready      memory request handshake with mem_addr/wen/wdata/wmask
//   mem_rsp_valid/mem_rdata  memory response
//   err                      sticky timeout flag
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // IFU
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [31:0]       ifu_rdata,
  // LSU
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [31:0]       lsu_rdata,
  // memory
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        rsp_hit;
  logic        deliver;
  logic [31:0] deliver_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
`endif

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant == OWN_LSU));
      grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // A response (real or timed out) is delivered on the WAIT -> RESP edge.
  always_comb begin
    rsp_hit      = (state == S_WAIT) && mem_rsp_valid;
    deliver      = rsp_hit;
    deliver_data = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_hit  = (state == S_WAIT) && !mem_rsp_valid && (wait_cnt == WAIT_LAST);
    deliver      = rsp_hit || timeout_hit;
    if (timeout_hit) begin
      deliver_data = 32'hDEADBEEF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner         <= OWN_IFU;
      last_grant    <= OWN_LSU;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      err           <= 1'b0;
`endif
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_ifu) begin
            owner         <= OWN_IFU;
            last_grant    <= OWN_IFU;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= 4'b0000;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end else if (grant_lsu) begin
            owner         <= OWN_LSU;
            last_grant    <= OWN_LSU;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end

        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (deliver) begin
            if (owner == OWN_IFU) begin
              ifu_rsp_valid <= 1'b1;
              ifu_rdata     <= deliver_data;
            end else begin
              lsu_rsp_valid <= 1'b1;
              lsu_rdata     <= deliver_data;
            end
            state <= S_RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          if (timeout_hit) begin
            err <= 1'b1;
          end else if (!rsp_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef MEM_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset state, IFU read latency, round-robin
// ties, a stalled LSU write, reset during WAIT, and timeout behaviour (both
// with and without MEM_ARB_TIMEOUT_EN; the DUT is built with TIMEOUT=4).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rdata    (ifu_rdata),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rdata    (lsu_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the REQ cycle: memory accepts at once, answers next cycle with
  // d; checks the owner's response pulse and data, then returns in IDLE.
  task automatic serve(input logic own_lsu, input logic [31:0] d, input string tag);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = d;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    check({tag, "_rsp"},   own_lsu ? {31'd0, lsu_rsp_valid} : {31'd0, ifu_rsp_valid}, 32'd1);
    check({tag, "_rdata"}, own_lsu ? lsu_rdata : ifu_rdata, d);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_mem_wen",       {31'd0, mem_wen},       32'd0);
    check("rst_mem_addr",      mem_addr,               32'd0);
    check("rst_mem_wdata",     mem_wdata,              32'd0);
    check("rst_mem_wmask",     {28'd0, mem_wmask},     32'd0);
    check("rst_ifu_rsp",       {31'd0, ifu_rsp_valid}, 32'd0);
    check("rst_lsu_rsp",       {31'd0, lsu_rsp_valid}, 32'd0);
    check("rst_ifu_rdata",     ifu_rdata,              32'd0);
    check("rst_lsu_rdata",     lsu_rdata,              32'd0);
    check("rst_err",           {31'd0, err},           32'd0);
    rst_n = 1'b1;
    step();

    // IFU read, minimum latency: grant c0, req c1, rsp c3
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    #1;
    check("t1_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
    check("t1_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    step();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    check("t1_c1_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("t1_c1_addr",      mem_addr,               32'h8000_0000);
    check("t1_c1_wen",       {31'd0, mem_wen},       32'd0);
    check("t1_c1_wmask",     {28'd0, mem_wmask},     32'd0);
    check("t1_c1_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("t1_c2_req_valid", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0010_0073;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    check("t1_c3_ifu_rsp",   {31'd0, ifu_rsp_valid}, 32'd1);
    check("t1_c3_ifu_rdata", ifu_rdata,              32'h0010_0073);
    check("t1_c3_lsu_rsp",   {31'd0, lsu_rsp_valid}, 32'd0);
    step();
    check("t1_c4_ifu_rsp",   {31'd0, ifu_rsp_valid}, 32'd0);
    check("t1_c4_ifu_hold",  ifu_rdata,              32'h0010_0073);
    check("t1_c4_lsu_rsp",   {31'd0, lsu_rsp_valid}, 32'd0);

    // Round-robin ties from a fresh reset: IFU, LSU, IFU
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0000_1000;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_2000;
    #1;
    check("tie1_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
    check("tie1_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    step();
    ifu_req_valid = 1'b0;
    check("tie1_addr", mem_addr, 32'h0000_1000);
    serve(1'b0, 32'h1111_1111, "tie1");
    ifu_req_valid = 1'b1;
    #1;
    check("tie2_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
    check("tie2_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
    step();
    lsu_req_valid = 1'b0;
    check("tie2_addr", mem_addr, 32'h0000_2000);
    serve(1'b1, 32'h2222_2222, "tie2");
    lsu_req_valid = 1'b1;
    #1;
    check("tie3_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
    check("tie3_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    check("tie3_addr", mem_addr, 32'h0000_1000);
    serve(1'b0, 32'h3333_3333, "tie3");

    // LSU write, memory stalls 5 cycles; a stray mem_rsp_valid in REQ is ignored
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h1234_5678;
    lsu_wmask     = 4'b0011;
    #1;
    check("wr_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
    step();
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    for (int i = 0; i < 5; i++) begin
      check("wr_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check("wr_stall_addr",  mem_addr,               32'h8000_1000);
      check("wr_stall_wen",   {31'd0, mem_wen},       32'd1);
      check("wr_stall_wdata", mem_wdata,              32'h1234_5678);
      check("wr_stall_wmask", {28'd0, mem_wmask},     32'h3);
      mem_rsp_valid = (i == 2);
      step();
    end
    mem_rsp_valid = 1'b0;
    check("wr_still_req",  {31'd0, mem_req_valid}, 32'd1);
    check("wr_no_early",   {31'd0, lsu_rsp_valid}, 32'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wr_wait_rsp", {31'd0, lsu_rsp_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    check("wr_ack",        {31'd0, lsu_rsp_valid}, 32'd1);
    check("wr_lsu_rdata",  lsu_rdata,              32'hCAFE_F00D);
    check("wr_ifu_rsp",    {31'd0, ifu_rsp_valid}, 32'd0);
    check("wr_ifu_hold",   ifu_rdata,              32'h3333_3333);
    step();
    check("wr_ack_end",    {31'd0, lsu_rsp_valid}, 32'd0);

    // Reset during WAIT, then a late memory response
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_3000;
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rw_addr",      mem_addr,               32'd0);
    check("rw_lsu_rdata", lsu_rdata,              32'd0);
    step();
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hBAD0_BAD0;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    check("rw_late_lsu", {31'd0, lsu_rsp_valid}, 32'd0);
    check("rw_late_ifu", {31'd0, ifu_rsp_valid}, 32'd0);
    check("rw_late_data", lsu_rdata,             32'd0);
    step();
    check("rw_late_lsu2", {31'd0, lsu_rsp_valid}, 32'd0);
    check("rw_idle_valid", {31'd0, mem_req_valid}, 32'd0);
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0000_4000;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_5000;
    #1;
    check("rw_tie_ifu", {31'd0, ifu_req_ready}, 32'd1);
    check("rw_tie_lsu", {31'd0, lsu_req_ready}, 32'd0);
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    check("rw_next_addr", mem_addr, 32'h0000_4000);
    serve(1'b0, 32'h4444_4444, "rw_next");

    // Timeout: memory accepts but never answers
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0000_6000;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("to_wait_rsp", {31'd0, ifu_rsp_valid}, 32'd0);
      check("to_wait_err", {31'd0, err},           32'd0);
      step();
    end
    check("to_rsp",   {31'd0, ifu_rsp_valid}, 32'd1);
    check("to_rdata", ifu_rdata,              32'hDEAD_BEEF);
    check("to_err",   {31'd0, err},           32'd1);
    step();
    check("to_rsp_end",   {31'd0, ifu_rsp_valid}, 32'd0);
    check("to_err_stick", {31'd0, err},           32'd1);
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_7000;
    step();
    lsu_req_valid = 1'b0;
    serve(1'b1, 32'h5555_5555, "to_after");
    check("to_err_stick2", {31'd0, err}, 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check("nto_rsp",       {31'd0, ifu_rsp_valid}, 32'd0);
    check("nto_rdata",     ifu_rdata,              32'h4444_4444);
    check("nto_err",       {31'd0, err},           32'd0);
    check("nto_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h6666_6666;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    check("nto_late_rsp",   {31'd0, ifu_rsp_valid}, 32'd1);
    check("nto_late_rdata", ifu_rdata,              32'h6666_6666);
    check("nto_late_err",   {31'd0, err},           32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-002 SHALL have parameter TIMEOUT, default 255: number of WAIT cycles before abort; used only with MEM_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have IFU ports: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in ADDR_W; ifu_rsp_valid out 1; ifu_rdata out 32.
REQ-006 SHALL have LSU ports: lsu_req_valid in 1; lsu_req_ready out 1; lsu_addr in ADDR_W; lsu_wen in 1; lsu_wdata in 32; lsu_wmask in 4; lsu_rsp_valid out 1; lsu_rdata out 32.
REQ-007 SHALL have memory ports: mem_req_valid out 1; mem_req_ready in 1; mem_addr out ADDR_W; mem_wen out 1; mem_wdata out 32; mem_wmask out 4; mem_rsp_valid in 1; mem_rdata in 32.
REQ-008 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-009 SHALL implement FSM with states IDLE, REQ, WAIT, RESP; at most one transaction outstanding.
REQ-010 SHALL assert ifu_req_ready/lsu_req_ready only in IDLE, and only for the granted requester (one-hot or zero).
REQ-011 Arbitration in IDLE: single valid requester wins; both valid -> requester not granted last wins (round-robin via last_grant register).
REQ-012 On grant handshake SHALL latch owner, addr, wen, wdata, wmask and go to REQ next cycle; IFU transactions latch wen=0, wmask=4'b0000.
REQ-013 In REQ SHALL drive mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to WAIT.
REQ-014 In WAIT SHALL drive mem_req_valid=0; on mem_rsp_valid=1 latch mem_rdata and go to RESP.
REQ-015 In RESP SHALL pulse owner's rsp_valid for exactly one cycle with latched rdata (writes also get the pulse as acknowledge), then return to IDLE.
REQ-016 SHALL ignore mem_rsp_valid in any state other than WAIT.
REQ-017 ifu_rdata/lsu_rdata SHALL hold last value delivered to that requester between responses.
REQ-018 Minimum latency: grant at cycle 0, mem_req_valid at cycle 1, with mem_req_ready=1 at cycle 1 and mem_rsp_valid=1 at cycle 2, rsp_valid at cycle 3.
REQ-019 A requester deasserting valid while not granted SHALL have no effect; a new request is not accepted before RESP completes.

Reset
REQ-020 rst_n=0 SHALL immediately force: state IDLE, last_grant=LSU (IFU wins first tie), all rsp_valid=0, mem_req_valid=0, mem_wen=0, mem_addr/wdata=0, mem_wmask=0, rdata outputs=0, err=0, timeout counter=0.
REQ-021 Reset mid-transaction SHALL abandon it without any rsp_valid; a late mem_rsp_valid after reset SHALL be ignored.

Configuration
REQ-022 With MEM_ARB_TIMEOUT_EN defined: counter clears on entering WAIT and increments each WAIT cycle; when TIMEOUT cycles pass without mem_rsp_valid, go to RESP with rdata=32'hDEADBEEF and set err=1 until reset.
REQ-023 Without MEM_ARB_TIMEOUT_EN: WAIT persists indefinitely, no counter exists, err is tied to 0.

Verification
REQ-024 IFU read 0x80000000, mem_req_ready=1 immediately, mem_rsp_valid one cycle later with 0x00100073 -> ifu_rsp_valid at cycle 3, ifu_rdata=0x00100073, lsu_rsp_valid stays 0.
REQ-025 Both valid after reset, then both again -> first grant IFU, second LSU; third tie after LSU -> IFU.
REQ-026 LSU write addr 0x80001000 wdata 0x12345678 wmask 4'b0011, mem_req_ready low 5 cycles -> mem_* fields stable all 5 cycles, lsu_rsp_valid single-cycle pulse after response.
REQ-027 rst_n low during WAIT, then mem_rsp_valid pulse -> no rsp_valid, state IDLE, next request served normally.
REQ-028 MEM_ARB_TIMEOUT_EN, TIMEOUT=4, no mem_rsp_valid -> rsp_valid after 4 WAIT cycles, rdata=0xDEADBEEF, err=1 sticky; without macro, err=0 and no response.
